// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 serial receiver feeding a first-word-fall-through byte
//             FIFO with a valid/ready output and sticky overrun/framing flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  input  logic [15:0]              baud,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   MIN_BIT  = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_p_q;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bper_q, bper_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push;
  logic        ferr_set;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ferr_q;
  logic          full, pop, push_ok, ovf_set;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and previous-sample register; idle level is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
      rx_p_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_p_q <= rx_s;
    end
  end

  // Receiver state, bit timing and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bper_q  <= MIN_BIT;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bper_q  <= bper_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: mid-bit sampling relative to the detected start edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bper_d   = bper_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_p_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
          bper_d  = (baud < MIN_BIT) ? MIN_BIT : baud;
        end
      end
      ST_START: begin
        if (cnt_q == (bper_q >> 1) - 16'd1) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = 16'd0;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == bper_q - 16'd1) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = 16'd0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == bper_q - 16'd1) begin
          state_d = ST_IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign full    = (count_q == FULL_CNT);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Occupancy update from accepted pushes and pops.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= shift_q;
    end
  end

  // Pointers, occupancy and sticky error flags (set dominates clear).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
      if (ferr_set) begin
        ferr_q <= 1'b1;
      end else if (clr_err) begin
        ferr_q <= 1'b0;
      end
    end
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem_q[rd_q] : 8'h00;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Randomised scoreboard bench for uart_rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          rx      = 1'b1;
  logic [15:0]   baud    = 16'd8;
  logic          m_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic [CW-1:0] count;
  logic          overflow;
  logic          frame_err;

  int total = 0;
  int bad   = 0;

  // Expected FIFO contents in delivery order.
  logic [7:0] model_q[$];
  bit exp_ovf  = 1'b0;
  bit exp_ferr = 1'b0;
  bit rand_en  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .baud      (baud),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
    check({tag, "_ferr"},  32'(frame_err), 32'(exp_ferr));
  endtask

  // Drives one frame plus a two-bit idle gap. Position k counts cycles
  // after the start edge; pop_at >= 0 raises m_ready for exactly that cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bt,
                            input int pop_at, output int t_valid);
    logic [9:0] bits;
    bits    = {stop, d, 1'b0};
    t_valid = -1;
    for (int k = 0; k < 12 * bt; k++) begin
      rx = (k < 10 * bt) ? bits[k / bt] : 1'b1;
      if (pop_at >= 0) begin
        if (k == pop_at) m_ready = 1'b1;
        else if (k == pop_at + 1) m_ready = 1'b0;
      end
      if (t_valid < 0 && m_valid) t_valid = k;
      step();
    end
  endtask

  // Good frame; the model decides acceptance from occupancy alone.
  task automatic send_byte(input logic [7:0] d, input int bt, input bit coincide);
    int tv;
    int pa;
    if (model_q.size() < DEPTH || coincide) model_q.push_back(d);
    else exp_ovf = 1'b1;
    // Stop bit is sampled mid-bit; the push lands SYNC+1 cycles after
    // the line-time sample point of 9.5 bit periods.
    pa = coincide ? (SYNC + 1 + bt / 2 + 9 * bt - 1) : -1;
    send_frame(d, 1'b1, bt, pa, tv);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (model_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    m_ready = 1'b0;
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles", tag, model_q.size(), n);
      model_q.delete();
    end
    step();
    check({tag, "_empty"}, 32'(count), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  // Monitor: consumes expected bytes whenever a handshake will occur.
  initial begin : monitor
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && m_valid) check("hold", 32'(m_data), 32'(pd));
        if (m_valid && m_ready) begin
          if (model_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop: got byte %02h expected none", m_data);
          end else begin
            check("data", 32'(m_data), 32'(model_q.pop_front()));
          end
        end
        pv = m_valid; pr = m_ready; pd = m_data;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int tv;
    int bt;
    logic [15:0] b;

    // Reset state
    step(); step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'(m_data), 32'd0);
    check_state("rst");
    rstn = 1'b1;
    repeat (3) step();

    // Single byte with latency bound
    baud = 16'd8;
    model_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 8, -1, tv);
    check("t1_latency_ok", 32'(tv >= 0 && tv <= 2 + 4 + 9 * 8 + 2), 32'd1);
    check("t1_data", 32'(m_data), 32'hA5);
    check_state("t1");
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t1_valid_after_pop", 32'(m_valid), 32'd0);
    check_state("t1_pop");

    // Fill past capacity
    baud = 16'd4;
    for (int i = 0; i < 17; i++) send_byte(8'(i), 4, 1'b0);
    check("t2_count16", 32'(count), 32'd16);
    check_state("t2");
    wait_drain("t2");
    pulse_clr();
    exp_ovf = 1'b0;
    check_state("t2_clr");

    // Full with coincident pop on the push cycle
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 4, 1'b0);
    send_byte(8'h55, 4, 1'b1);
    check("t3_count16", 32'(count), 32'd16);
    check_state("t3");
    wait_drain("t3");

    // Framing error, recovery, clear
    baud = 16'd8;
    send_frame(8'h3C, 1'b0, 8, -1, tv);
    exp_ferr = 1'b1;
    check_state("t4_ferr");
    send_byte(8'h81, 8, 1'b0);
    check("t4_data", 32'(m_data), 32'h81);
    check_state("t4_next");
    wait_drain("t4");
    pulse_clr();
    exp_ferr = 1'b0;
    check_state("t4_clr");

    // Glitch rejection, then clamped baud
    baud = 16'd16;
    rx = 1'b0;
    step(); step();
    rx = 1'b1;
    repeat (60) step();
    check("t5_glitch_valid", 32'(m_valid), 32'd0);
    check_state("t5_glitch");
    baud = 16'd1;
    send_byte(8'h5A, 4, 1'b0);
    check("t5_data", 32'(m_data), 32'h5A);
    check_state("t5_clamp");
    wait_drain("t5");

    // Reset mid-frame with three bytes queued
    baud = 16'd8;
    send_byte(8'h11, 8, 1'b0);
    send_byte(8'h22, 8, 1'b0);
    send_byte(8'h33, 8, 1'b0);
    check("t6_count3", 32'(count), 32'd3);
    rx = 1'b0;
    repeat (24) step();
    #2;
    rstn = 1'b0;
    #1;
    model_q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_data",  32'(m_data), 32'd0);
    check_state("t6_rst");
    rx = 1'b1;
    repeat (4) step();
    rstn = 1'b1;
    repeat (4) step();
    check_state("t6_rel");
    send_byte(8'hC3, 8, 1'b0);
    check("t6_data", 32'(m_data), 32'hC3);
    check_state("t6_next");
    wait_drain("t6");

    // Random bytes, random baud (including clamped values), random m_ready
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b    = 16'($urandom_range(0, 12));
      bt   = (b < 16'd4) ? 4 : int'(b);
      baud = b;
      send_byte(8'($urandom_range(0, 255)), bt, 1'b0);
      check_state("rnd");
    end
    rand_en = 1'b0;
    wait_drain("rnd");
    check_state("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
